// File: rtl/sysreg_sr1_file.sv
// sysreg_sr1_file
//   Architectural system register SR1 and its interrupt shadow PSR1.
//   Writes that change MMUMOD go through a flush handshake first:
//   IDLE -> FLUSH (wait for iFLUSH_ACK) -> COMMIT -> IDLE.
//   SR1 field map: MMUMOD=[1:0], IM=[2], CMOD=[6:5].
//   Optional feature macro: SYSREG_WRITE_COUNT_EN adds the oWRITE_COUNT
//   committed-writeback counter. When the macro is undefined, the port and
//   the counter logic are both absent.
module sysreg_sr1_file #(
  parameter logic [31:0] P_SR1_INIT    = 32'h0000_0000,
  parameter logic [1:0]  P_KERNEL_CMOD = 2'b00
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iWB_VALID,
  input  logic [31:0] iWB_DATA,
  output logic        oWB_BUSY,
  input  logic        iIRQ_ENTRY,
  input  logic        iIRET,
  output logic        oFLUSH_REQ,
  input  logic        iFLUSH_ACK,
  output logic [31:0] oSR1,
  output logic [1:0]  oSR1_MMUMOD,
  output logic        oSR1_IM,
  output logic [1:0]  oSR1_CMOD,
  output logic [31:0] oPSR1
`ifdef SYSREG_WRITE_COUNT_EN
  ,
  output logic [15:0] oWRITE_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] sr1;
  logic [31:0] psr1;
  logic [31:0] pending;

  // SR1 as it looks after interrupt entry: IM cleared, CMOD forced to kernel,
  // MMUMOD and every other bit kept.
  function automatic logic [31:0] irq_entry_value(input logic [31:0] v);
    logic [31:0] r;
    r      = v;
    r[2]   = 1'b0;
    r[6:5] = P_KERNEL_CMOD;
    return r;
  endfunction

  // Candidate values in IDLE. IRET restores PSR1 and a writeback takes the
  // supplied word. Either one commits directly only if MMUMOD is unchanged.
  logic iret_same;
  logic wb_same;
  assign iret_same = (psr1[1:0] == sr1[1:0]);
  assign wb_same   = (iWB_DATA[1:0] == sr1[1:0]);

  // Register, shadow and flush sequencer, prioritised IRQ > IRET > WB in IDLE.
  // NOTE: the async clear and the sync clear load identical values; the sync
  // one is just the first branch under the clock, not a second reset net.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state   <= S_IDLE;
      sr1     <= P_SR1_INIT;
      psr1    <= '0;
      pending <= '0;
    end else if (iRESET_SYNC) begin
      state   <= S_IDLE;
      sr1     <= P_SR1_INIT;
      psr1    <= '0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments here let psr1 capture the old sr1
      // while sr1 takes its new value on the same edge.
      unique case (state)
        S_IDLE: begin
          if (iIRQ_ENTRY) begin
            psr1 <= sr1;
            sr1  <= irq_entry_value(sr1);
          end else if (iIRET) begin
            if (iret_same) begin
              sr1 <= psr1;
            end else begin
              pending <= psr1;
              state   <= S_FLUSH;
            end
          end else if (iWB_VALID) begin
            if (wb_same) begin
              sr1 <= iWB_DATA;
            end else begin
              pending <= iWB_DATA;
              state   <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (iIRQ_ENTRY) begin
            psr1  <= sr1;
            sr1   <= irq_entry_value(sr1);
            state <= S_IDLE;
          end else if (iFLUSH_ACK) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          sr1   <= pending;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SYSREG_WRITE_COUNT_EN
  logic        pending_wb;
  logic [15:0] write_count;
  logic        wb_direct;

  assign wb_direct = (state == S_IDLE) && !iIRQ_ENTRY && !iIRET && iWB_VALID && wb_same;

  // Counts SR1 updates sourced from writeback, on both the direct and flush paths.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pending_wb  <= 1'b0;
      write_count <= '0;
    end else if (iRESET_SYNC) begin
      pending_wb  <= 1'b0;
      write_count <= '0;
    end else begin
      if (state == S_IDLE) begin
        pending_wb <= !iIRQ_ENTRY && !iIRET;
      end
      if (wb_direct || ((state == S_COMMIT) && pending_wb)) begin
        write_count <= write_count + 16'd1;
      end
    end
  end

  assign oWRITE_COUNT = write_count;
`endif

  assign oWB_BUSY    = (state != S_IDLE);
  assign oFLUSH_REQ  = (state == S_FLUSH);
  assign oSR1        = sr1;
  assign oSR1_MMUMOD = sr1[1:0];
  assign oSR1_IM     = sr1[2];
  assign oSR1_CMOD   = sr1[6:5];
  assign oPSR1       = psr1;

endmodule

// File: tb/tb_sysreg_sr1_file.sv
// tb_sysreg_sr1_file
//   Directed bench for sysreg_sr1_file with hand-computed expectations.
//   Inputs change and outputs are sampled 1 ns after each rising edge.
//   Define SYSREG_WRITE_COUNT_EN for both files to include the counter checks.
module tb_sysreg_sr1_file;

  logic        iCLOCK;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iWB_VALID;
  logic [31:0] iWB_DATA;
  logic        oWB_BUSY;
  logic        iIRQ_ENTRY;
  logic        iIRET;
  logic        oFLUSH_REQ;
  logic        iFLUSH_ACK;
  logic [31:0] oSR1;
  logic [1:0]  oSR1_MMUMOD;
  logic        oSR1_IM;
  logic [1:0]  oSR1_CMOD;
  logic [31:0] oPSR1;
`ifdef SYSREG_WRITE_COUNT_EN
  logic [15:0] oWRITE_COUNT;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sysreg_sr1_file dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iWB_VALID   (iWB_VALID),
    .iWB_DATA    (iWB_DATA),
    .oWB_BUSY    (oWB_BUSY),
    .iIRQ_ENTRY  (iIRQ_ENTRY),
    .iIRET       (iIRET),
    .oFLUSH_REQ  (oFLUSH_REQ),
    .iFLUSH_ACK  (iFLUSH_ACK),
    .oSR1        (oSR1),
    .oSR1_MMUMOD (oSR1_MMUMOD),
    .oSR1_IM     (oSR1_IM),
    .oSR1_CMOD   (oSR1_CMOD),
    .oPSR1       (oPSR1)
`ifdef SYSREG_WRITE_COUNT_EN
    ,
    .oWRITE_COUNT(oWRITE_COUNT)
`endif
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  // Pulse one writeback request for a single cycle.
  task automatic wb(input logic [31:0] d);
    iWB_VALID = 1'b1;
    iWB_DATA  = d;
    tick();
    iWB_VALID = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag, input logic [31:0] sr1_exp);
    check({tag, "_sr1"},   oSR1, sr1_exp);
    check({tag, "_busy"},  {31'd0, oWB_BUSY}, 32'd0);
    check({tag, "_flush"}, {31'd0, oFLUSH_REQ}, 32'd0);
  endtask

  initial begin
    inRESET     = 1'b1;
    iRESET_SYNC = 1'b0;
    iWB_VALID   = 1'b0;
    iWB_DATA    = '0;
    iIRQ_ENTRY  = 1'b0;
    iIRET       = 1'b0;
    iFLUSH_ACK  = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #2 inRESET = 1'b0;
    #2;
    check_idle_outs("rst", 32'h0);
    check("rst_psr1", oPSR1, 32'h0);
    tick();
    inRESET = 1'b1;
    tick();

    // Same MMUMOD: direct commit, never busy.
    wb(32'h0000_0064);
    check_idle_outs("t1", 32'h0000_0064);
    check("t1_cmod", {30'd0, oSR1_CMOD}, 32'h3);
    check("t1_im",   {31'd0, oSR1_IM}, 32'h1);

    // Sync clear brings SR1 back to the init value.
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    check("sync_rst_sr1", oSR1, 32'h0);

    // MMUMOD change 00->01: flush, held request, late ack, commit.
    wb(32'h0000_0001);
    check("t2_flush", {31'd0, oFLUSH_REQ}, 32'h1);
    check("t2_busy",  {31'd0, oWB_BUSY}, 32'h1);
    check("t2_sr1_hold", oSR1, 32'h0);
    iWB_VALID = 1'b1;           // a stalled writeback while busy is ignored
    iWB_DATA  = 32'h0000_0F00;
    iIRET     = 1'b1;           // IRET outside IDLE is ignored
    tick();
    iIRET = 1'b0;
    repeat (2) tick();
    iWB_VALID = 1'b0;
    check("t2_flush_wait", {31'd0, oFLUSH_REQ}, 32'h1);
    iFLUSH_ACK = 1'b1;
    tick();
    iFLUSH_ACK = 1'b0;
    check("t2_commit_flush", {31'd0, oFLUSH_REQ}, 32'h0);
    check("t2_commit_busy",  {31'd0, oWB_BUSY}, 32'h1);
    check("t2_commit_sr1",   oSR1, 32'h0);
    tick();
    check_idle_outs("t2_done", 32'h0000_0001);
    check("t2_mmumod", {30'd0, oSR1_MMUMOD}, 32'h1);

    // Zero-wait ack path to load 0x24 (MMUMOD 01->00).
    wb(32'h0000_0024);
    iFLUSH_ACK = 1'b1;
    tick();
    iFLUSH_ACK = 1'b0;
    check("t3_zw_sr1_pre", oSR1, 32'h0000_0001);
    tick();
    check_idle_outs("t3_zw", 32'h0000_0024);

    // IRQ entry: 0x24 loses IM (bit 2) and CMOD[0] (bit 5), giving 0x00.
    iIRQ_ENTRY = 1'b1;
    tick();
    iIRQ_ENTRY = 1'b0;
    check("t3_irq_psr1", oPSR1, 32'h0000_0024);
    check_idle_outs("t3_irq", 32'h0000_0000);
    // IRET: PSR1 MMUMOD 00 matches, so it commits directly.
    iIRET = 1'b1;
    tick();
    iIRET = 1'b0;
    check_idle_outs("t3_iret", 32'h0000_0024);

    // IRQ during FLUSH aborts the pending 0x2 write.
    wb(32'h0000_0002);
    check("t4_flush", {31'd0, oFLUSH_REQ}, 32'h1);
    iIRQ_ENTRY = 1'b1;
    tick();
    iIRQ_ENTRY = 1'b0;
    check_idle_outs("t4_abort", 32'h0000_0000);
    check("t4_abort_psr1", oPSR1, 32'h0000_0024);
    iFLUSH_ACK = 1'b1;
    tick();
    iFLUSH_ACK = 1'b0;
    tick();
    check_idle_outs("t4_late_ack", 32'h0000_0000);

    // IRQ in COMMIT is ignored: pending 0x1 still lands, PSR1 untouched.
    wb(32'h0000_0001);
    iFLUSH_ACK = 1'b1;
    tick();
    iFLUSH_ACK = 1'b0;
    iIRQ_ENTRY = 1'b1;
    tick();
    iIRQ_ENTRY = 1'b0;
    check_idle_outs("t4_commit_irq", 32'h0000_0001);
    check("t4_commit_irq_psr1", oPSR1, 32'h0000_0024);

    // Same-cycle IRQ+IRET+WB from SR1=0x65: only IRQ entry happens.
    wb(32'h0000_0065);
    check("t5_pre", oSR1, 32'h0000_0065);
    iIRQ_ENTRY = 1'b1;
    iIRET      = 1'b1;
    iWB_VALID  = 1'b1;
    iWB_DATA   = 32'h0000_0005;
    tick();
    iIRQ_ENTRY = 1'b0;
    iIRET      = 1'b0;
    iWB_VALID  = 1'b0;
    check_idle_outs("t5_prio", 32'h0000_0001);
    check("t5_prio_psr1", oPSR1, 32'h0000_0065);

    // Async reset mid-FLUSH clears every output without waiting for a clock edge.
    wb(32'h0000_0003);
    check("t5_flush", {31'd0, oFLUSH_REQ}, 32'h1);
    #2 inRESET = 1'b0;
    #1;
    check_idle_outs("t5_async", 32'h0);
    check("t5_async_psr1", oPSR1, 32'h0);
    tick();
    inRESET = 1'b1;
    tick();

`ifdef SYSREG_WRITE_COUNT_EN
    check("cnt_rst", {16'd0, oWRITE_COUNT}, 32'h0);
    iWB_VALID = 1'b1;
    iWB_DATA  = 32'h0000_0000;
    repeat (65535) tick();
    check("cnt_ffff", {16'd0, oWRITE_COUNT}, 32'h0000_FFFF);
    tick();
    iWB_VALID = 1'b0;
    check("cnt_wrap", {16'd0, oWRITE_COUNT}, 32'h0);
    iIRQ_ENTRY = 1'b1;
    tick();
    iIRQ_ENTRY = 1'b0;
    iIRET = 1'b1;
    tick();
    iIRET = 1'b0;
    check("cnt_irq_iret", {16'd0, oWRITE_COUNT}, 32'h0);
    wb(32'h0000_0002);
    iFLUSH_ACK = 1'b1;
    tick();
    iFLUSH_ACK = 1'b0;
    tick();
    check("cnt_flush_path", {16'd0, oWRITE_COUNT}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
